gain_ramp_ctrl: RTL and testbench
=================================

GAIN_RAMP_CTRL -- requirements
Module: gain_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 1, meaning the per-update gain/balance increment magnitude (1..127).
REQ-002 SHALL have parameter TICK_DIV, default 1, meaning the number of frame_tick pulses per ramp update (1..255).
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-cycle pulse per 256-bit audio frame (din_val of the gain/balance multiplier).
REQ-006 SHALL have port cfg_wr_val  input  1  config write request.
REQ-007 SHALL have port cfg_wr_rdy  output  1  config write accept.
REQ-008 SHALL have port cfg_addr  input  4  0-7 = channel gain, 8-11 = pair balance, 12-15 = reserved.
REQ-009 SHALL have port cfg_wr_data  input  8  signed two's-complement value.
REQ-010 SHALL have port cfg_commit  input  1  one-cycle pulse to apply the shadow set.
REQ-011 SHALL have port mute_req  input  1  level; ramp all gains to 0 while high.
REQ-012 SHALL have port gain  output  64  eight 8-bit signed current gains, channel n at [8n+:8].
REQ-013 SHALL have port bal  output  32  four 8-bit signed current balances, pair p at [8p+:8].
REQ-014 SHALL have port ramp_busy  output  1  high while any current value differs from its effective target.
REQ-015 SHALL have port ramp_done  output  1  one-cycle pulse when the last current value reaches its target.

Function
REQ-016 A write SHALL occur when cfg_wr_val && cfg_wr_rdy; data goes to shadow register [cfg_addr]; addresses 12-15 accepted and discarded.
REQ-017 cfg_commit SHALL copy all 12 shadow values into the target set on the next clock edge; a write accepted in the same cycle as cfg_commit SHALL be included in the committed set.
REQ-018 FSM states: IDLE (current == effective target), COPY (one cycle after commit), RAMP (stepping); IDLE->COPY on commit, COPY->RAMP if any mismatch else IDLE, RAMP->IDLE when all match, RAMP->COPY on commit (retarget mid-ramp, ramp continues from current values).
REQ-019 cfg_wr_rdy SHALL be 0 in COPY, 1 otherwise.
REQ-020 Effective gain target SHALL be 0 while mute_req is high, else the committed gain; balance target SHALL be unaffected by mute_req; a change of mute_req in IDLE SHALL enter RAMP the next cycle.
REQ-021 A tick counter SHALL count frame_tick pulses in RAMP, reset to 0 on entering RAMP; an update SHALL occur on the tick that brings it to TICK_DIV, then it wraps to 0.
REQ-022 On update, each current value SHALL move toward its target by STEP using 9-bit signed difference; if |diff| <= STEP it SHALL equal target (no overshoot, no wrap past -128/127).
REQ-023 gain/bal SHALL change only on the clock edge after an updating frame_tick, giving the multiplier one full frame of stable coefficients.
REQ-024 ramp_done SHALL pulse on the RAMP->IDLE transition only; ramp_busy SHALL equal (state != IDLE).
REQ-025 frame_tick in COPY or IDLE SHALL be ignored.

Reset
REQ-026 On rstn low: shadow, target, gain, bal = 0; state IDLE; tick counter 0; cfg_wr_rdy = 1; ramp_busy = 0; ramp_done = 0.
REQ-027 Reset mid-ramp SHALL abort immediately; no update SHALL occur on the first frame_tick after release unless a commit precedes it.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, address map constants (GAIN_BASE=0, BAL_BASE=8) and the 8-bit coefficient width.
REQ-029 One sub-module ramp_step SHALL implement the saturating step-toward-target of REQ-022 for one 8-bit value, instantiated 12 times.

Verification
REQ-030 Write gain ch0 = 8'h10, commit, STEP=4, TICK_DIV=1 -> gain[7:0] 0x04,0x08,0x0C,0x10 on successive ticks, ramp_done once, busy low after.
REQ-031 Write bal p1 = -3 (8'hFD), STEP=2 -> bal[15:8] 0xFE then 0xFD (no overshoot).
REQ-032 TICK_DIV=3, gain ch7 target 2, STEP=1 -> gain changes only on ticks 3 and 6.
REQ-033 Mid-ramp (gain ch2 at 5 heading to 20) commit target 0 -> cfg_wr_rdy low one cycle, ch2 steps down 4,3,2,1,0.
REQ-034 All gains 0x40, mute_req high, STEP=127 -> all gains 0 after one tick; mute_req low -> back to 0x40 after one tick, bal unchanged throughout.
REQ-035 rstn asserted during RAMP -> gain, bal, busy 0 in same cycle; frame_ticks after release leave outputs at 0.

Source files
------------

// File: rtl/gain_ramp_ctrl_pkg.sv
// Shared definitions for the gain/balance ramp controller.
// Holds the FSM state encoding, the config address map and the
// coefficient width and type used by gain_ramp_ctrl and ramp_step.
package gain_ramp_ctrl_pkg;

    localparam int COEF_W = 8;
    localparam int N_GAIN = 8;
    localparam int N_BAL  = 4;
    localparam int N_COEF = N_GAIN + N_BAL;

    // Config address map: gains, then balances, then reserved slots.
    localparam logic [3:0] GAIN_BASE = 4'd0;
    localparam logic [3:0] BAL_BASE  = 4'd8;
    localparam logic [3:0] RSVD_BASE = 4'd12;

    typedef logic signed [COEF_W-1:0] coef_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_RAMP = 2'd2
    } state_t;

endpackage

// File: rtl/gain_ramp_ctrl_ramp_step.sv
// ramp_step: combinational step of one signed coefficient toward its target.
// Ports:
//   cur - current signed value
//   tgt - target signed value
//   nxt - cur moved toward tgt by STEP, clamped to tgt (never overshoots)
module ramp_step
    import gain_ramp_ctrl_pkg::*;
#(
    parameter int STEP = 1
) (
    input  coef_t cur,
    input  coef_t tgt,
    output coef_t nxt
);

    localparam logic signed [COEF_W:0] STEP_S = (COEF_W+1)'(STEP);

    // The difference is taken one bit wider so -128..127 spans never wrap.
    // When |diff| > STEP the stepped value lies strictly between cur and tgt,
    // so the truncation back to COEF_W bits is always exact.
    function automatic coef_t step_toward(coef_t c, coef_t t);
        logic signed [COEF_W:0] c_ext;
        logic signed [COEF_W:0] t_ext;
        logic signed [COEF_W:0] diff;
        logic signed [COEF_W:0] moved;
        c_ext = {c[COEF_W-1], c};
        t_ext = {t[COEF_W-1], t};
        diff  = t_ext - c_ext;
        if (diff > STEP_S) begin
            moved = c_ext + STEP_S;
            return moved[COEF_W-1:0];
        end else if (diff < -STEP_S) begin
            moved = c_ext - STEP_S;
            return moved[COEF_W-1:0];
        end
        return t;
    endfunction

    assign nxt = step_toward(cur, tgt);

endmodule

// File: rtl/gain_ramp_ctrl.sv
// gain_ramp_ctrl: double-buffered gain/balance coefficients with ramping.
// Config writes land in a shadow set; cfg_commit copies it to the target set.
// Current values step toward the effective target once every TICK_DIV frames.
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   frame_tick           - one pulse per audio frame
//   cfg_wr_val/rdy       - config write handshake
//   cfg_addr/cfg_wr_data - 0-7 gain, 8-11 balance, 12-15 discarded
//   cfg_commit           - apply the shadow set
//   mute_req             - ramp all gains to 0 while high
//   gain, bal            - current coefficients (8 gains, 4 balances)
//   ramp_busy, ramp_done - ramp status
module gain_ramp_ctrl
    import gain_ramp_ctrl_pkg::*;
#(
    parameter int STEP     = 1,
    parameter int TICK_DIV = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        frame_tick,
    input  logic        cfg_wr_val,
    output logic        cfg_wr_rdy,
    input  logic [3:0]  cfg_addr,
    input  logic [7:0]  cfg_wr_data,
    input  logic        cfg_commit,
    input  logic        mute_req,
    output logic [63:0] gain,
    output logic [31:0] bal,
    output logic        ramp_busy,
    output logic        ramp_done
);

    localparam logic [7:0] TICK_LAST = 8'(TICK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] tick_cnt_q;
    logic       done_q;
    coef_t      shadow_q [N_COEF];
    coef_t      shadow_d [N_COEF];
    coef_t      target_q [N_COEF];
    coef_t      cur_q    [N_COEF];
    coef_t      eff      [N_COEF];
    coef_t      nxt      [N_COEF];
    logic       wr_fire;
    logic       mismatch;
    logic       tick_upd;

    assign wr_fire  = cfg_wr_val && cfg_wr_rdy;
    assign tick_upd = (state_q == ST_RAMP) && frame_tick && (tick_cnt_q == TICK_LAST);

    // Shadow set including this cycle's write, so a same-cycle commit sees it.
    always_comb begin
        for (int i = 0; i < N_COEF; i++) shadow_d[i] = shadow_q[i];
        if (wr_fire && (cfg_addr < RSVD_BASE)) shadow_d[cfg_addr] = cfg_wr_data;
    end

    // Mute overrides gain targets only; balances keep their committed value.
    always_comb begin
        mismatch = 1'b0;
        for (int i = 0; i < N_COEF; i++) begin
            eff[i] = (mute_req && (i < N_GAIN)) ? coef_t'(0) : target_q[i];
            if (cur_q[i] != eff[i]) mismatch = 1'b1;
        end
    end

    for (genvar g = 0; g < N_COEF; g++) begin : g_step
        ramp_step #(.STEP(STEP)) u_step (
            .cur (cur_q[g]),
            .tgt (eff[g]),
            .nxt (nxt[g])
        );
    end

    always_comb begin
        state_d    = state_q;
        cfg_wr_rdy = (state_q != ST_COPY);
        ramp_busy  = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit)    state_d = ST_COPY;
                else if (mismatch) state_d = ST_RAMP;  // mute_req changed
            end
            ST_COPY: begin
                if (cfg_commit)    state_d = ST_COPY;
                else if (mismatch) state_d = ST_RAMP;
                else               state_d = ST_IDLE;
            end
            ST_RAMP: begin
                if (cfg_commit)     state_d = ST_COPY;
                else if (!mismatch) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            done_q     <= 1'b0;
            for (int i = 0; i < N_COEF; i++) begin
                shadow_q[i] <= '0;
                target_q[i] <= '0;
                cur_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ST_RAMP) && (state_d == ST_IDLE);
            if ((state_d == ST_RAMP) && (state_q != ST_RAMP))
                tick_cnt_q <= '0;
            else if ((state_q == ST_RAMP) && frame_tick)
                tick_cnt_q <= tick_upd ? 8'd0 : tick_cnt_q + 8'd1;
            for (int i = 0; i < N_COEF; i++) begin
                shadow_q[i] <= shadow_d[i];
                if (cfg_commit) target_q[i] <= shadow_d[i];
                if (tick_upd)   cur_q[i]    <= nxt[i];
            end
        end
    end

    assign ramp_done = done_q;

    always_comb begin
        gain = '0;
        bal  = '0;
        for (int i = 0; i < N_GAIN; i++) gain[8*i +: 8] = cur_q[i];
        for (int p = 0; p < N_BAL; p++)  bal[8*p +: 8]  = cur_q[N_GAIN + p];
    end

endmodule

// File: tb/tb_gain_ramp_ctrl.sv
// Directed bench for gain_ramp_ctrl: five instances with different
// STEP/TICK_DIV settings, each exercised by its own directed sequence.
module tb_gain_ramp_ctrl;

    localparam int NI = 5;
    localparam int STEP_V [NI] = '{4, 2, 1, 1, 127};
    localparam int TDIV_V [NI] = '{1, 1, 3, 1, 1};

    logic          clk = 1'b0;
    logic          rstn;
    logic [NI-1:0] frame_tick, wr_val, commit, mute;
    logic [3:0]    addr  [NI];
    logic [7:0]    wdata [NI];
    logic [NI-1:0] wr_rdy, busy, done;
    logic [63:0]   gain  [NI];
    logic [31:0]   bal   [NI];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        gain_ramp_ctrl #(.STEP(STEP_V[g]), .TICK_DIV(TDIV_V[g])) u_dut (
            .clk         (clk),
            .rstn        (rstn),
            .frame_tick  (frame_tick[g]),
            .cfg_wr_val  (wr_val[g]),
            .cfg_wr_rdy  (wr_rdy[g]),
            .cfg_addr    (addr[g]),
            .cfg_wr_data (wdata[g]),
            .cfg_commit  (commit[g]),
            .mute_req    (mute[g]),
            .gain        (gain[g]),
            .bal         (bal[g]),
            .ramp_busy   (busy[g]),
            .ramp_done   (done[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are sampled there too.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int k, input logic [3:0] a, input logic [7:0] d);
        wr_val[k] = 1'b1; addr[k] = a; wdata[k] = d;
        cyc();
        wr_val[k] = 1'b0;
    endtask

    task automatic cmt(input int k);
        commit[k] = 1'b1;
        cyc();
        commit[k] = 1'b0;
    endtask

    task automatic tick(input int k);
        frame_tick[k] = 1'b1;
        cyc();
        frame_tick[k] = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_up  [4];
        logic [7:0] exp_td  [6];
        logic [7:0] exp_dn  [5];
        exp_up = '{8'h04, 8'h08, 8'h0C, 8'h10};
        exp_td = '{8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2};
        exp_dn = '{8'd4, 8'd3, 8'd2, 8'd1, 8'd0};

        rstn = 1'b0;
        frame_tick = '0; wr_val = '0; commit = '0; mute = '0;
        for (int i = 0; i < NI; i++) begin addr[i] = '0; wdata[i] = '0; end
        cyc(); cyc();
        check("rst_gain", gain[0], 64'h0);
        check("rst_bal",  bal[0], 64'h0);
        check("rst_rdy",  wr_rdy[0], 1'b1);
        check("rst_busy", busy[0], 1'b0);
        check("rst_done", done[0], 1'b0);
        rstn = 1'b1;
        cyc();

        // Instance 0: STEP=4, ramp ch0 to 0x10.
        tick(0);
        check("idle_tick_ignored", gain[0], 64'h0);
        wr(0, 4'd0, 8'h10);
        check("no_commit_yet", busy[0], 1'b0);
        cmt(0);
        check("copy_rdy_low", wr_rdy[0], 1'b0);
        cyc();
        check("ramp_busy", busy[0], 1'b1);
        check("ramp_rdy_high", wr_rdy[0], 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(0);
            check("up_gain0", gain[0][7:0], exp_up[i]);
            check("up_no_done", done[0], 1'b0);
            if (i == 0) begin
                cyc(); cyc();
                check("hold_between_ticks", gain[0][7:0], 8'h04);
            end
        end
        cyc();
        check("up_done", done[0], 1'b1);
        check("up_idle", busy[0], 1'b0);
        cyc();
        check("up_done_once", done[0], 1'b0);

        // Instance 1: STEP=2, balance pair 1 to -3 without overshoot.
        wr(1, 4'd9, 8'hFD);
        cmt(1);
        cyc();
        tick(1);
        check("bal_step1", bal[1][15:8], 8'hFE);
        tick(1);
        check("bal_step2", bal[1][15:8], 8'hFD);
        cyc();
        check("bal_done", done[1], 1'b1);
        tick(1);
        check("bal_hold", bal[1], 64'h0000_FD00);

        // Instance 2: STEP=1, TICK_DIV=3, ch7 to 2.
        wr(2, 4'd7, 8'd2);
        cmt(2);
        cyc();
        for (int i = 0; i < 6; i++) begin
            tick(2);
            check("div3_gain7", gain[2][63:56], exp_td[i]);
        end

        // Instance 3: STEP=1, retarget mid-ramp with a same-cycle write+commit.
        wr(3, 4'd2, 8'd20);
        cmt(3);
        cyc();
        for (int i = 0; i < 5; i++) tick(3);
        check("mid_at5", gain[3][23:16], 8'd5);
        wr_val[3] = 1'b1; addr[3] = 4'd2; wdata[3] = 8'd0; commit[3] = 1'b1;
        cyc();
        wr_val[3] = 1'b0; commit[3] = 1'b0;
        check("retarget_rdy_low", wr_rdy[3], 1'b0);
        check("retarget_hold", gain[3][23:16], 8'd5);
        cyc();
        check("retarget_rdy_back", wr_rdy[3], 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(3);
            check("down_gain2", gain[3][23:16], exp_dn[i]);
        end
        cyc();
        check("down_done", done[3], 1'b1);

        // Instance 4: STEP=127, mute and unmute.
        for (int i = 0; i < 8; i++) wr(4, 4'(i), 8'h40);
        wr(4, 4'd8, 8'h11);
        wr(4, 4'd13, 8'h7F);
        cmt(4);
        cyc();
        tick(4);
        check("all_40", gain[4], {8{8'h40}});
        check("bal_set", bal[4], 64'h11);
        cyc();
        check("mute_pre_idle", busy[4], 1'b0);
        mute[4] = 1'b1;
        cyc();
        check("mute_enters_ramp", busy[4], 1'b1);
        check("mute_waits_tick", gain[4], {8{8'h40}});
        tick(4);
        check("muted", gain[4], 64'h0);
        check("mute_bal", bal[4], 64'h11);
        cyc();
        check("mute_done", done[4], 1'b1);
        mute[4] = 1'b0;
        cyc();
        tick(4);
        check("unmuted", gain[4], {8{8'h40}});
        check("unmute_bal", bal[4], 64'h11);

        // Reset in the middle of a ramp on instance 0.
        wr(0, 4'd1, 8'h30);
        cmt(0);
        cyc();
        tick(0);
        check("pre_rst_gain", gain[0], 64'h0410);
        rstn = 1'b0;
        #1;
        check("async_gain", gain[0], 64'h0);
        check("async_busy", busy[0], 1'b0);
        check("async_gain4", gain[4], 64'h0);
        check("async_bal4", bal[4], 64'h0);
        cyc(); cyc();
        rstn = 1'b1;
        for (int i = 0; i < 3; i++) tick(0);
        check("post_rst_gain", gain[0], 64'h0);
        check("post_rst_busy", busy[0], 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
